trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Receiving end of the execution-result path: consumes the per-instruction exec result (exception, xRET, branch) at commit time.
- Turns each result into a pipeline flush plus PC redirect.
- Owns the machine-mode trap CSRs: mtvec, mepc, mcause, mstatus.MIE/MPIE.
- Sits between the execution units and the fetch stage; fully sequential, single clock.

Parameters:
- XLEN, 32, data/address width.
- EX_W, 4, width of exception code field.
- FLUSH_CYCLES, 2, cycles flush is held before redirect (>=1).
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- res_valid  in  1  commit result valid.
- res_ready  out  1  unit can accept a result.
- res_pc  in  XLEN  PC of committing instruction.
- res_ex_valid  in  1  instruction raised an exception.
- res_ex  in  EX_W  exception code.
- res_ret_valid  in  1  instruction is MRET.
- res_br_valid  in  1  instruction redirects control flow.
- res_br_target  in  XLEN  branch target.
- flush  out  1  kill all younger in-flight instructions.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  XLEN  new fetch PC.
- csr_addr  in  12  CSR address (0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause).
- csr_we  in  1  CSR write strobe.
- csr_wdata  in  XLEN  CSR write data.
- csr_rdata  out  XLEN  combinational CSR read data.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; flush=0, redirect_valid=0, redirect_pc=0, res_ready=1.
  - mtvec=MTVEC_RST, mepc=0, mcause=0, MIE=0, MPIE=0.
- Handshake: a result is accepted when res_valid && res_ready. res_ready=1 only in IDLE.
- Priority among flags of an accepted result: ex_valid > ret_valid > br_valid.
  - Accepted with none set: retires; no action; stays IDLE.
- Exception accepted, at the next edge:
  - mepc <= res_pc (low 2 bits forced 0).
  - mcause <= zero-extended res_ex (bit XLEN-1 = 0).
  - MPIE <= MIE; MIE <= 0.
  - target <= {mtvec[XLEN-1:2],2'b00} (direct mode only).
  - state -> FLUSH.
- MRET accepted, at the next edge:
  - MIE <= MPIE; MPIE <= 1.
  - target <= mepc.
  - state -> FLUSH.
- Branch accepted: target <= res_br_target; state -> FLUSH. No CSR change.
- FLUSH state:
  - flush=1, res_ready=0.
  - Internal counter counts FLUSH_CYCLES cycles, then state -> REDIRECT.
- REDIRECT state:
  - redirect_valid=1, redirect_pc=target, flush=1, res_ready=0 for exactly one cycle.
  - Then -> IDLE.
  - Total latency from accept edge to redirect_valid high: FLUSH_CYCLES+1 cycles.
- CSR port:
  - Reads are combinational from current register values. Unmapped addresses read 0; writes to them are ignored.
  - mstatus read: bit3=MIE, bit7=MPIE, other bits 0.
  - mtvec write stores wdata with low 2 bits cleared.
  - mepc write clears the low 2 bits.
  - mcause write is stored as-is.
- Same-edge CSR write and trap/MRET update to the same field: the trap/MRET update wins; the CSR write is dropped.
- res_valid while not ready: ignored; the producer holds the result.
- Reset mid-FLUSH: returns to IDLE next edge; no redirect emitted; CSRs restored to reset values.

Test Plan:
1. Reset, mtvec written 0x0000_1003, exception res_pc=0x100, res_ex=2 -> csr reads mtvec=0x1000, mepc=0x100, mcause=2; flush high 3 cycles; redirect_valid 1 cycle with redirect_pc=0x1000, 3 cycles after accept.
2. MIE=1 via mstatus write 0x8, exception, then MRET -> after trap mstatus reads 0x80; after MRET it reads 0x88; MRET redirect_pc=mepc.
3. Branch res_br_target=0x2000 with res_ex_valid=1 in the same beat -> exception wins; redirect_pc=mtvec; mepc updated; no redirect to 0x2000.
4. res_valid held high during FLUSH/REDIRECT -> res_ready=0; no second accept until IDLE; CSRs unchanged.
5. csr_we to mepc with data 0x55 on the same edge as an exception accept with pc=0x200 -> mepc=0x200.
6. rst asserted in the 2nd FLUSH cycle -> no redirect_valid pulse ever; all outputs and CSRs at reset values the next cycle.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-time trap/MRET/branch handling. Turns each accepted result
// into a flush window followed by a one-cycle fetch redirect, and owns the
// machine-mode trap CSRs (mtvec, mepc, mcause, mstatus.MIE/MPIE).
module trap_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     EX_W         = 4,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0] MTVEC_RST    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_ex_valid,
    input  logic [EX_W-1:0] res_ex,
    input  logic            res_ret_valid,
    input  logic            res_br_valid,
    input  logic [XLEN-1:0] res_br_target,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic [11:0]     csr_addr,
    input  logic            csr_we,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [XLEN-1:0]   target, target_nxt;
    logic              take_ex, take_ret;

    logic [XLEN-1:0]   mtvec, mepc, mcause;
    logic              mie, mpie;

    // PC alignment bits are dropped: mepc is always word aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^res_pc[1:0];

    // Next-state: accept in IDLE with ex > ret > br priority, count the flush window.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        take_ex    = 1'b0;
        take_ret   = 1'b0;
        case (state)
            IDLE: begin
                if (res_valid) begin
                    cnt_nxt = '0;
                    if (res_ex_valid) begin
                        take_ex    = 1'b1;
                        target_nxt = {mtvec[XLEN-1:2], 2'b00};
                        state_nxt  = FLUSH;
                    end else if (res_ret_valid) begin
                        take_ret   = 1'b1;
                        target_nxt = mepc;
                        state_nxt  = FLUSH;
                    end else if (res_br_valid) begin
                        target_nxt = res_br_target;
                        state_nxt  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = REDIRECT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            target         <= '0;
            res_ready      <= 1'b1;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            target         <= target_nxt;
            res_ready      <= (state_nxt == IDLE);
            flush          <= (state_nxt != IDLE);
            redirect_valid <= (state_nxt == REDIRECT);
            if (state_nxt == REDIRECT) begin
                redirect_pc <= target_nxt;
            end
        end
    end

    // Trap CSRs: software writes, overridden field-wise by a same-edge trap/MRET.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec  <= MTVEC_RST;
            mepc   <= '0;
            mcause <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        if (!take_ex && !take_ret) begin
                            mie  <= csr_wdata[3];
                            mpie <= csr_wdata[7];
                        end
                    end
                    ADDR_MTVEC:  mtvec <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MEPC:   if (!take_ex) mepc <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: if (!take_ex) mcause <= csr_wdata;
                    default: ;
                endcase
            end
            if (take_ex) begin
                mepc   <= {res_pc[XLEN-1:2], 2'b00};
                mcause <= XLEN'(res_ex);
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (take_ret) begin
                mie    <= mpie;
                mpie   <= 1'b1;
            end
        end
    end

    // Combinational CSR read; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mie;
                csr_rdata[7] = mpie;
            end
            ADDR_MTVEC:  csr_rdata = mtvec;
            ADDR_MEPC:   csr_rdata = mepc;
            ADDR_MCAUSE: csr_rdata = mcause;
            default:     csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed plus random stimulus; a reference model queues the
// expected redirect targets and a monitor checks the DUT outputs every cycle.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned EX_W = 4;
    localparam int unsigned FC   = 2;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic            clk = 1'b0;
    logic            rst;
    logic            res_valid, res_ready;
    logic [XLEN-1:0] res_pc;
    logic            res_ex_valid;
    logic [EX_W-1:0] res_ex;
    logic            res_ret_valid, res_br_valid;
    logic [XLEN-1:0] res_br_target;
    logic            flush, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata, csr_rdata;

    trap_ctrl #(.XLEN(XLEN), .EX_W(EX_W), .FLUSH_CYCLES(FC), .MTVEC_RST(32'h0)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_ex_valid(res_ex_valid), .res_ex(res_ex), .res_ret_valid(res_ret_valid),
        .res_br_valid(res_br_valid), .res_br_target(res_br_target),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural CSR values plus remaining busy cycles.
    logic [XLEN-1:0] m_mtvec, m_mepc, m_mcause;
    logic            m_mie, m_mpie;
    int              busy = 0;
    logic [XLEN-1:0] exp_q[$];
    bit              mon_en = 0;
    int              flush_run = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input logic [11:0] a);
        logic [XLEN-1:0] r;
        r = '0;
        case (a)
            A_MSTATUS: begin r[3] = m_mie; r[7] = m_mpie; end
            A_MTVEC:   r = m_mtvec;
            A_MEPC:    r = m_mepc;
            A_MCAUSE:  r = m_mcause;
            default:   r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_mie = 0; m_mpie = 0;
        busy = 0;
        exp_q.delete();
    endtask

    // One clock: apply inputs, check CSR read, clock, then update the model.
    task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic exv,
                        input logic [EX_W-1:0] ex, input logic retv, input logic brv,
                        input logic [XLEN-1:0] brt, input logic we, input logic [11:0] addr,
                        input logic [XLEN-1:0] wd, input logic r);
        bit acc, blk_st, blk_ec;
        logic [XLEN-1:0] old_mtvec, old_mepc;
        res_valid = v; res_pc = pc; res_ex_valid = exv; res_ex = ex;
        res_ret_valid = retv; res_br_valid = brv; res_br_target = brt;
        csr_we = we; csr_addr = addr; csr_wdata = wd; rst = r;
        #1;
        if (mon_en) check("csr_rdata", csr_rdata, model_read(addr));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc = v && (busy == 0);
            if (busy > 0) busy--;
            old_mtvec = m_mtvec; old_mepc = m_mepc;
            blk_st = acc && (exv || retv);
            blk_ec = acc && exv;
            if (we) begin
                if (addr == A_MSTATUS && !blk_st) begin m_mie = wd[3]; m_mpie = wd[7]; end
                if (addr == A_MTVEC) m_mtvec = wd & ~32'h3;
                if (addr == A_MEPC && !blk_ec) m_mepc = wd & ~32'h3;
                if (addr == A_MCAUSE && !blk_ec) m_mcause = wd;
            end
            if (acc && exv) begin
                m_mepc = pc & ~32'h3; m_mcause = {28'h0, ex};
                m_mpie = m_mie; m_mie = 0;
                exp_q.push_back(old_mtvec & ~32'h3); busy = FC + 1;
            end else if (acc && retv) begin
                m_mie = m_mpie; m_mpie = 1;
                exp_q.push_back(old_mepc); busy = FC + 1;
            end else if (acc && brv) begin
                exp_q.push_back(brt); busy = FC + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, '0, 0, 12'h7C0, '0, 0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
        step(0, '0, 0, '0, 0, 0, '0, 1, a, d, 0);
    endtask

    task automatic expect_csr(input string name, input logic [11:0] a, input logic [XLEN-1:0] v);
        csr_we = 0; res_valid = 0; csr_addr = a;
        #1;
        check(name, csr_rdata, v);
    endtask

    // Monitor: handshake/flush shape each cycle, redirect targets from the queue.
    initial begin
        logic [XLEN-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                check("res_ready", res_ready, (busy == 0));
                check("flush", flush, (busy != 0));
                check("redirect_valid", redirect_valid, (busy == 1));
                flush_run = flush ? flush_run + 1 : 0;
                if (redirect_valid) begin
                    check("redirect_latency", flush_run, FC + 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_redirect", redirect_pc, 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        check("redirect_pc", redirect_pc, e);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        step(0, '0, 0, '0, 0, 0, '0, 0, 12'h7C0, '0, 1);
        step(0, '0, 0, '0, 0, 0, '0, 0, 12'h7C0, '0, 1);
        mon_en = 1;
        check("rst_res_ready", res_ready, 1);
        check("rst_flush", flush, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        expect_csr("rst_mtvec", A_MTVEC, 0);
        expect_csr("rst_mstatus", A_MSTATUS, 0);

        // Exception into direct-mode mtvec.
        csr_write(A_MTVEC, 32'h0000_1003);
        step(1, 32'h100, 1, 4'd2, 0, 0, '0, 0, 12'h7C0, '0, 0);
        idle(FC + 2);
        expect_csr("t1_mtvec", A_MTVEC, 32'h1000);
        expect_csr("t1_mepc", A_MEPC, 32'h100);
        expect_csr("t1_mcause", A_MCAUSE, 32'h2);

        // MIE/MPIE across trap and MRET.
        csr_write(A_MSTATUS, 32'h8);
        expect_csr("t2_mstatus_set", A_MSTATUS, 32'h8);
        step(1, 32'h304, 1, 4'd11, 0, 0, '0, 0, 12'h7C0, '0, 0);
        idle(FC + 2);
        expect_csr("t2_mstatus_trap", A_MSTATUS, 32'h80);
        step(1, 32'h500, 0, '0, 1, 0, '0, 0, 12'h7C0, '0, 0);
        idle(FC + 2);
        expect_csr("t2_mstatus_mret", A_MSTATUS, 32'h88);

        // Exception beats branch in the same beat.
        step(1, 32'h40C, 1, 4'd5, 0, 1, 32'h2000, 0, 12'h7C0, '0, 0);
        idle(FC + 2);
        expect_csr("t3_mepc", A_MEPC, 32'h40C);

        // Producer holds res_valid through the busy window.
        for (int i = 0; i < FC + 3; i++)
            step(1, 32'h600, 0, '0, 0, 1, 32'h3000 + 32'(i * 4), 0, 12'h7C0, '0, 0);
        idle(FC + 2);
        expect_csr("t4_mepc", A_MEPC, 32'h40C);

        // Same-edge mepc write loses to the exception.
        step(1, 32'h200, 1, 4'd3, 0, 0, '0, 1, A_MEPC, 32'h55, 0);
        idle(FC + 2);
        expect_csr("t5_mepc", A_MEPC, 32'h200);

        // Reset during the second flush cycle cancels the redirect.
        step(1, 32'h700, 1, 4'd1, 0, 0, '0, 0, 12'h7C0, '0, 0);
        idle(1);
        step(0, '0, 0, '0, 0, 0, '0, 0, 12'h7C0, '0, 1);
        check("t6_redirect_pc", redirect_pc, 0);
        expect_csr("t6_mepc", A_MEPC, 0);
        expect_csr("t6_mcause", A_MCAUSE, 0);
        idle(FC + 3);

        // Random results and CSR traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            case ($urandom_range(0, 5))
                0: a = A_MSTATUS;
                1: a = A_MTVEC;
                2: a = A_MEPC;
                3: a = A_MCAUSE;
                4: a = 12'h344;
                default: a = 12'h301;
            endcase
            step($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0), EX_W'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom,
                 ($urandom_range(0, 3) == 0), a, $urandom, ($urandom_range(0, 199) == 0));
        end
        idle(FC + 3);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
